// File: rtl/axi_sram_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_sram_pkg
//  Description : Shared response codes, FSM encodings and helpers for the
//                single-beat AXI3 SRAM slave.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_sram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        R_IDLE = 3'b001,
        R_WAIT = 3'b010,
        R_RESP = 3'b100
    } rd_state_t;

    typedef enum logic [2:0] {
        W_IDLE = 3'b001,
        W_WAIT = 3'b010,
        W_RESP = 3'b100
    } wr_state_t;

    // Any set bit above the word-index field means the byte address is outside the RAM.
    function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned addr_w);
        return (addr >> (addr_w + 2)) != 32'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_sram_slave_bram_bytewe.sv
`default_nettype none
// ============================================================================
//  Module      : bram_bytewe
//  Description : 2**ADDR_W x 32-bit RAM with per-byte write enables, one
//                synchronous read port and one write port (read-before-write).
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_bytewe #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [31:0]       o_rd_data,
    input  logic [3:0]        i_wr_be,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [31:0]       i_wr_data
);

    logic [31:0] r_mem [0:(1<<ADDR_W)-1];

    // Read and write share one process so a same-address collision returns the old word.
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
        for (int i = 0; i < 4; i++) begin
            if (i_wr_be[i]) begin
                r_mem[i_wr_addr][8*i +: 8] <= i_wr_data[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi_sram_slave
//  Description : Single-beat AXI3 slave memory with programmable read/write
//                latency; one outstanding read and one outstanding write.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [2:0]  arsize,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [2:0]  awsize,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam logic [CNT_W-1:0] C_RD_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] C_WR_LOAD = CNT_W'(WR_LAT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------ read
    rd_state_t         r_rd_state;
    rd_state_t         w_rd_state_nxt;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic [3:0]        r_ar_id;
    logic [31:0]       r_ar_addr;
    logic              w_rd_fire;
    logic              w_ar_hs;
    logic [3:0]        w_fire_id;
    logic [31:0]       w_fire_addr;
    logic              w_fire_err;
    logic              r_rvalid;
    logic [1:0]        r_rresp;
    logic [3:0]        r_rid;
    logic [31:0]       w_bram_q;

    // ----------------------------------------------------------------- write
    wr_state_t         r_wr_state;
    wr_state_t         w_wr_state_nxt;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic              r_aw_got;
    logic              r_w_got;
    logic [3:0]        r_aw_id;
    logic [31:0]       r_aw_addr;
    logic [31:0]       r_w_data;
    logic [3:0]        r_w_strb;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_commit;
    logic              w_wr_err;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic [3:0]        r_bid;
    logic [3:0]        w_bram_be;

    logic              w_unused_ok;
    assign w_unused_ok = ^{arsize, awsize};

    // The read sample fires in the cycle the count would reach zero, so a
    // single-cycle latency samples straight from the AR channel.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        arready        = 1'b0;
        w_rd_fire      = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                arready = ~areset;
                if (arvalid && !areset) begin
                    if (RD_LAT == 1) begin
                        w_rd_fire      = 1'b1;
                        w_rd_state_nxt = R_RESP;
                    end else begin
                        w_rd_state_nxt = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_rd_cnt == C_CNT_ONE) begin
                    w_rd_fire      = 1'b1;
                    w_rd_state_nxt = R_RESP;
                end
            end
            R_RESP: begin
                if (rready) begin
                    w_rd_state_nxt = R_IDLE;
                end
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    assign w_ar_hs     = arvalid & arready;
    assign w_fire_addr = (r_rd_state == R_IDLE) ? araddr : r_ar_addr;
    assign w_fire_id   = (r_rd_state == R_IDLE) ? arid   : r_ar_id;
    assign w_fire_err  = addr_out_of_range(w_fire_addr, ADDR_W);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rd_state <= R_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rid     <= 4'd0;
            r_rd_cnt  <= '0;
            r_ar_id   <= 4'd0;
            r_ar_addr <= 32'd0;
        end else begin
            if (w_ar_hs) begin
                r_ar_id   <= arid;
                r_ar_addr <= araddr;
                r_rd_cnt  <= C_RD_LOAD;
            end else if (r_rd_state == R_WAIT) begin
                r_rd_cnt <= r_rd_cnt - C_CNT_ONE;
            end
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rresp  <= w_fire_err ? RESP_SLVERR : RESP_OKAY;
                r_rid    <= w_fire_id;
            end else if (r_rvalid && rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // The RAM output register only updates on a sample, so it stays stable while stalled.
    assign rdata  = (r_rvalid && r_rresp == RESP_OKAY) ? w_bram_q : 32'd0;
    assign rvalid = r_rvalid;
    assign rlast  = r_rvalid;
    assign rresp  = r_rresp;
    assign rid    = r_rid;

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        awready        = 1'b0;
        wready         = 1'b0;
        w_commit       = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                awready = ~r_aw_got & ~areset;
                wready  = ~r_w_got & ~areset;
                if ((r_aw_got || (awvalid && awready)) && (r_w_got || (wvalid && wready))) begin
                    w_wr_state_nxt = W_WAIT;
                end
            end
            W_WAIT: begin
                if (r_wr_cnt == '0) begin
                    w_commit       = 1'b1;
                    w_wr_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_wr_state_nxt = W_IDLE;
                end
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    assign w_aw_hs  = awvalid & awready;
    assign w_w_hs   = wvalid & wready;
    assign w_wr_err = addr_out_of_range(r_aw_addr, ADDR_W);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_state <= W_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_aw_id   <= 4'd0;
            r_aw_addr <= 32'd0;
            r_w_data  <= 32'd0;
            r_w_strb  <= 4'd0;
            r_wr_cnt  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_bid     <= 4'd0;
        end else begin
            if (w_aw_hs) begin
                r_aw_got  <= 1'b1;
                r_aw_id   <= awid;
                r_aw_addr <= awaddr;
            end
            if (w_w_hs) begin
                r_w_got  <= 1'b1;
                r_w_data <= wdata;
                r_w_strb <= wstrb;
            end
            if (r_wr_state == W_IDLE && w_wr_state_nxt == W_WAIT) begin
                r_wr_cnt <= C_WR_LOAD;
            end else if (r_wr_state == W_WAIT && r_wr_cnt != '0) begin
                r_wr_cnt <= r_wr_cnt - C_CNT_ONE;
            end
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
                r_bid    <= r_aw_id;
            end else if (r_bvalid && bready) begin
                r_bvalid <= 1'b0;
                r_aw_got <= 1'b0;
                r_w_got  <= 1'b0;
            end
        end
    end

    assign bvalid = r_bvalid;
    assign bresp  = r_bresp;
    assign bid    = r_bid;

    // A reset landing on the commit cycle must leave the RAM untouched.
    assign w_bram_be = (w_commit && !w_wr_err && !areset) ? r_w_strb : 4'b0000;

    bram_bytewe #(
        .ADDR_W (ADDR_W)
    ) u_bram (
        .clk       (aclk),
        .i_rd_en   (w_rd_fire & ~w_fire_err & ~areset),
        .i_rd_addr (w_fire_addr[ADDR_W+1:2]),
        .o_rd_data (w_bram_q),
        .i_wr_be   (w_bram_be),
        .i_wr_addr (r_aw_addr[ADDR_W+1:2]),
        .i_wr_data (r_w_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_sram_slave
//  Description : Directed and randomized checks of axi_sram_slave against a
//                word-array reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_sram_slave;

    localparam int ADDR_W = 14;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [2:0]  arsize = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [2:0]  awsize = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [31:0] mdl [int unsigned];

    always #5 aclk = ~aclk;

    axi_sram_slave #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT),
        .WR_LAT (WR_LAT)
    ) dut (
        .aclk    (aclk),    .areset  (areset),
        .arid    (arid),    .araddr  (araddr),  .arsize (arsize),
        .arvalid (arvalid), .arready (arready),
        .rid     (rid),     .rdata   (rdata),   .rresp  (rresp),
        .rlast   (rlast),   .rvalid  (rvalid),  .rready (rready),
        .awid    (awid),    .awaddr  (awaddr),  .awsize (awsize),
        .awvalid (awvalid), .awready (awready),
        .wdata   (wdata),   .wstrb   (wstrb),   .wvalid (wvalid),
        .wready  (wready),
        .bid     (bid),     .bresp   (bresp),   .bvalid (bvalid),
        .bready  (bready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    function automatic bit oor(input logic [31:0] a);
        return (a >> (ADDR_W + 2)) != 32'd0;
    endfunction

    function automatic int unsigned widx(input logic [31:0] a);
        return (a >> 2) & ((32'd1 << ADDR_W) - 32'd1);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int stall, input bit early);
        int k;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        logic [31:0] held;
        exp_r = oor(addr) ? 2'b10 : 2'b00;
        exp_d = oor(addr) ? 32'd0 : mdl[widx(addr)];
        arid = id; araddr = addr; arsize = 3'd2; arvalid = 1'b1;
        k = 0;
        while (!arready && k < 50) begin tick; k++; end
        check("ar_wait", 32'(k), 32'd0);
        tick;
        arvalid = 1'b0; araddr = $urandom;
        if (early) rready = 1'b1;
        k = 1;
        while (!rvalid && k < 50) begin
            check("ar_busy", 32'(arready), 32'd0);
            tick; k++;
        end
        check("rd_lat", 32'(k), 32'(RD_LAT));
        check("rdata", rdata, exp_d);
        check("rresp", 32'(rresp), 32'(exp_r));
        check("rid", 32'(rid), 32'(id));
        check("rlast", 32'(rlast), 32'd1);
        held = rdata;
        if (!early) begin
            for (int i = 0; i < stall; i++) begin
                tick;
                check("r_hold", 32'({rvalid, arready}), 32'b10);
                check("r_hold_data", rdata, held);
            end
            rready = 1'b1;
        end
        tick;
        rready = 1'b0;
        check("r_done", 32'({rvalid, rlast}), 32'd0);
    endtask

    // order: 0 = AW and W together, 1 = W first, 2 = AW first
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int order, input int gap, input int bstall);
        int k;
        logic [1:0] er;
        er = oor(addr) ? 2'b10 : 2'b00;
        awid = id; awaddr = addr; awsize = 3'd2; wdata = data; wstrb = strb;
        k = 0;
        if (order == 0) begin
            awvalid = 1'b1; wvalid = 1'b1;
            while (!(awready && wready) && k < 50) begin tick; k++; end
            check("wr_rdy", 32'(k), 32'd0);
            tick;
            awvalid = 1'b0; wvalid = 1'b0;
        end else if (order == 1) begin
            wvalid = 1'b1;
            while (!wready && k < 50) begin tick; k++; end
            check("w_rdy", 32'(k), 32'd0);
            tick;
            wvalid = 1'b0; wdata = $urandom;
            for (int i = 0; i < gap; i++) begin
                check("w_gap_rdy", 32'({awready, wready}), 32'b10);
                tick;
            end
            awvalid = 1'b1;
            tick;
            awvalid = 1'b0;
        end else begin
            awvalid = 1'b1;
            while (!awready && k < 50) begin tick; k++; end
            check("aw_rdy", 32'(k), 32'd0);
            tick;
            awvalid = 1'b0; awaddr = $urandom;
            for (int i = 0; i < gap; i++) begin
                check("aw_gap_rdy", 32'({awready, wready}), 32'b01);
                tick;
            end
            wvalid = 1'b1;
            tick;
            wvalid = 1'b0;
        end
        k = 1;
        while (!bvalid && k < 50) begin
            check("wr_busy", 32'({awready, wready}), 32'd0);
            tick; k++;
        end
        check("wr_lat", 32'(k), 32'(WR_LAT + 1));
        check("bid", 32'(bid), 32'(id));
        check("bresp", 32'(bresp), 32'(er));
        for (int i = 0; i < bstall; i++) begin
            tick;
            check("b_hold", 32'({bvalid, bid, bresp}), 32'({1'b1, id, er}));
        end
        bready = 1'b1;
        tick;
        bready = 1'b0;
        check("b_done", 32'(bvalid), 32'd0);
        if (er == 2'b00)
            mdl[widx(addr)] = merge(mdl.exists(widx(addr)) ? mdl[widx(addr)] : 32'd0, data, strb);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old;
        repeat (3) tick;
        check("rst_ready", 32'({arready, awready, wready}), 32'd0);
        check("rst_valid", 32'({rvalid, bvalid, rlast}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ids", 32'({rid, bid}), 32'd0);
        check("rst_resp", 32'({rresp, bresp}), 32'd0);
        areset = 1'b0;
        tick;
        check("idle_ready", 32'({arready, awready, wready}), 32'b111);

        // Full-word write then read back
        do_write(4'h3, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_read(4'h5, 32'h100, 0, 1'b0);

        // Partial byte write with W leading AW by three cycles
        do_write(4'h1, 32'h104, 32'h11223344, 4'hF, 2, 1, 2);
        do_write(4'h9, 32'h104, 32'h0000AB00, 4'b0010, 1, 2, 0);
        do_read(4'h2, 32'h105, 0, 1'b1);

        // Read stalled by rready low for four cycles
        do_read(4'hA, 32'h100, 4, 1'b0);

        // Same-cycle read sample and write commit to one word
        do_write(4'h0, 32'h200, 32'h0, 4'hF, 0, 0, 0);
        old = mdl[widx(32'h200)];
        araddr = 32'h200; arid = 4'h7; arsize = 3'd2; arvalid = 1'b1;
        awaddr = 32'h200; awid = 4'h6; awsize = 3'd2; awvalid = 1'b1;
        wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
        check("hz_ready", 32'({arready, awready, wready}), 32'b111);
        tick;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        tick;
        check("hz_valid", 32'({rvalid, bvalid}), 32'b11);
        check("hz_old", rdata, old);
        check("hz_ids", 32'({rid, bid}), 32'h76);
        rready = 1'b1; bready = 1'b1;
        tick;
        rready = 1'b0; bready = 1'b0;
        mdl[widx(32'h200)] = 32'h5;
        check("hz_done", 32'({rvalid, bvalid}), 32'd0);
        do_read(4'h8, 32'h200, 1, 1'b0);

        // Out-of-range accesses
        do_write(4'h1, 32'h0, 32'hCAFEF00D, 4'hF, 0, 0, 0);
        do_read(4'h4, 32'hFFFF0000, 1, 1'b0);
        do_write(4'h2, 32'hFFFF0000, 32'h12345678, 4'hF, 2, 0, 1);
        do_read(4'hB, 32'h0, 0, 1'b0);

        // No-op write with all strobes low
        do_write(4'hC, 32'h100, 32'h99999999, 4'h0, 0, 0, 0);
        do_read(4'hD, 32'h100, 0, 1'b0);

        // Reset while both paths wait on their latency counters
        do_write(4'h3, 32'h300, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
        araddr = 32'h100; arid = 4'h1; arvalid = 1'b1;
        awaddr = 32'h300; awid = 4'h2; awvalid = 1'b1;
        wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
        tick;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        areset = 1'b1;
        tick;
        check("mid_rst_valid", 32'({rvalid, bvalid}), 32'd0);
        check("mid_rst_ready", 32'({arready, awready, wready}), 32'd0);
        areset = 1'b0;
        tick;
        check("post_rst_ready", 32'({arready, awready, wready}), 32'b111);
        check("post_rst_valid", 32'({rvalid, bvalid}), 32'd0);
        do_read(4'h6, 32'h300, 0, 1'b0);
        do_read(4'h7, 32'h104, 0, 1'b0);

        // Randomized traffic over a small set of seeded words
        for (int i = 0; i < 8; i++)
            do_write(4'(i), 32'h400 + 32'(i * 4), $urandom, 4'hF, i % 3, i % 3, 0);
        for (int it = 0; it < 40; it++) begin
            logic [31:0] a;
            a = 32'h400 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) a = a | ($urandom_range(1, 16'hFFFF) << 16);
            if ($urandom_range(0, 1) == 0)
                do_read(4'($urandom_range(0, 15)), a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            else
                do_write(4'($urandom_range(0, 15)), a, $urandom, 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 8; i++)
            do_read(4'(i), 32'h400 + 32'(i * 4), 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
